// File: rtl/wb_timer_pkg.sv
// rtl/wb_timer_pkg.sv - register map, bus states and CTRL field positions for wb_timer
package wb_timer_pkg;

   typedef enum logic [2:0] {
      MTIME_LO     = 3'd0,
      MTIME_HI     = 3'd1,
      MTIMECMP_LO  = 3'd2,
      MTIMECMP_HI  = 3'd3,
      TIMER_CTRL   = 3'd4,
      TIMER_STATUS = 3'd5
   } timer_reg_t;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_RESP = 1'b1
   } wb_slave_state_t;

   localparam int TIMER_EN_BIT    = 0;
   localparam int TIMER_PRESC_LSB = 8;

endpackage

// File: rtl/wb_timer_prescaler.sv
// rtl/wb_timer_prescaler.sv - divide-by-(PRESC+1) tick generator, freezes when disabled
module timer_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic [PRESC_W-1:0] presc_i,
   input  logic               clear_i,
   output logic               tick_o
);

   logic [PRESC_W-1:0] cnt_q;

   // A clear restarts the period, so the tick of that cycle is swallowed too.
   assign tick_o = en_i & ~clear_i & (cnt_q == presc_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= (cnt_q == presc_i) ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone B4 classic machine timer: 64-bit mtime/mtimecmp, level irq
module wb_timer
   import wb_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int          PRESC_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        STB,
   input  logic        CYC,
   input  logic [31:0] ADR,
   input  logic [31:0] DAT_I,
   input  logic        WE,
   input  logic [2:0]  CTI_O,
   output logic [31:0] DAT_O,
   output logic        ACK,
   output logic        ERR,
   output logic        RTY,
   output logic        irq
);

   wb_slave_state_t    state_q;
   logic [63:0]        mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic [31:0]        hi_shadow_q, dat_q, rdata;
   logic [PRESC_W-1:0] presc_q;
   logic               en_q, ack_q, err_q, irq_q;
   logic [2:0]         off;
   logic               req, bad, wr, rd, ctrl_wr, tick;

   assign off     = ADR[4:2];
   assign req     = (state_q == WB_IDLE) & CYC & STB & ~ack_q & ~err_q;
   assign bad     = (ADR[1:0] != 2'b00) | (off > 3'd5)
                  | (ADR[31:5] != BASE_ADDR[31:5])
                  | ((CTI_O != 3'b000) & (CTI_O != 3'b111));
   assign wr      = req & ~bad & WE;
   assign rd      = req & ~bad & ~WE;
   assign ctrl_wr = wr & (off == TIMER_CTRL);

   timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk_i   (clk),
      .rst_ni  (rst),
      .en_i    (en_q),
      .presc_i (presc_q),
      .clear_i (ctrl_wr),
      .tick_o  (tick)
   );

   // Bus writes to mtime override a coincident tick; no carry crosses halves.
   always_comb begin
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      if (wr) begin
         case (off)
            MTIME_LO:    mtime_d    = {mtime_q[63:32], DAT_I};
            MTIME_HI:    mtime_d    = {DAT_I, mtime_q[31:0]};
            MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], DAT_I};
            MTIMECMP_HI: mtimecmp_d = {DAT_I, mtimecmp_q[31:0]};
            default:     ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         MTIME_LO:    rdata = mtime_q[31:0];
         MTIME_HI:    rdata = hi_shadow_q;
         MTIMECMP_LO: rdata = mtimecmp_q[31:0];
         MTIMECMP_HI: rdata = mtimecmp_q[63:32];
         TIMER_CTRL: begin
            rdata[TIMER_EN_BIT]                   = en_q;
            rdata[TIMER_PRESC_LSB +: PRESC_W]     = presc_q;
         end
         TIMER_STATUS: rdata[0] = irq_q;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= WB_IDLE;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         dat_q       <= '0;
         mtime_q     <= '0;
         mtimecmp_q  <= '1;
         en_q        <= 1'b0;
         presc_q     <= '0;
         hi_shadow_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         irq_q      <= en_q & (mtime_q >= mtimecmp_q);
         if (ctrl_wr) begin
            en_q    <= DAT_I[TIMER_EN_BIT];
            presc_q <= DAT_I[TIMER_PRESC_LSB +: PRESC_W];
         end
         // Snapshot the upper half so a following MTIME_HI read is coherent.
         if (rd && (off == MTIME_LO)) begin
            hi_shadow_q <= mtime_q[63:32];
         end
         case (state_q)
            WB_IDLE: begin
               if (req) begin
                  state_q <= WB_RESP;
                  ack_q   <= ~bad;
                  err_q   <= bad;
                  dat_q   <= rd ? rdata : '0;
               end
            end
            WB_RESP: begin
               state_q <= WB_IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               dat_q   <= '0;
            end
            default: state_q <= WB_IDLE;
         endcase
      end
   end

   assign DAT_O = dat_q;
   assign ACK   = ack_q;
   assign ERR   = err_q;
   assign RTY   = 1'b0;
   assign irq   = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// tb/tb_wb_timer.sv - directed self-checking bench for wb_timer
module tb_wb_timer;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        STB = 1'b0;
   logic        CYC = 1'b0;
   logic        WE  = 1'b0;
   logic [31:0] ADR = '0;
   logic [31:0] DAT_I = '0;
   logic [2:0]  CTI_O = '0;
   logic [31:0] DAT_O;
   logic        ACK, ERR, RTY, irq;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] rd;
   logic        ack, err, ack_irq;

   wb_timer #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .STB   (STB),
      .CYC   (CYC),
      .ADR   (ADR),
      .DAT_I (DAT_I),
      .WE    (WE),
      .CTI_O (CTI_O),
      .DAT_O (DAT_O),
      .ACK   (ACK),
      .ERR   (ERR),
      .RTY   (RTY),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called 1ns after a rising edge; returns 1ns after the edge following the response.
   task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                       input logic [2:0] cti);
      chk("idle_before_req", 64'({ACK, ERR}), 64'h0);
      ADR = adr; WE = we; DAT_I = wd; CTI_O = cti; STB = 1'b1; CYC = 1'b1;
      @(posedge clk); #1;
      rd = DAT_O; ack = ACK; err = ERR; ack_irq = irq;
      STB = 1'b0; CYC = 1'b0; WE = 1'b0; CTI_O = 3'b000;
      @(posedge clk); #1;
      chk("resp_single_cycle", 64'({ACK, ERR, DAT_O}), 64'h0);
   endtask

   task automatic wr32(input logic [31:0] off, input logic [31:0] d);
      xfer(BASE + off, 1'b1, d, 3'b000);
      chk("write_ack", 64'({ack, err}), 64'h2);
   endtask

   task automatic rd32(input logic [31:0] off, input logic [31:0] exp, input string tag);
      xfer(BASE + off, 1'b0, 32'h0, 3'b000);
      chk(tag, 64'({ack, err, rd}), 64'({2'b10, exp}));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({ACK, ERR, RTY, irq, DAT_O}), 64'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      rd32(32'h14, 32'h0, "status_reset");
      rd32(32'h00, 32'h0, "mtime_lo_reset");
      rd32(32'h0C, 32'hFFFF_FFFF, "mtimecmp_hi_reset");
      chk("irq_reset", 64'(irq), 64'h0);

      // EN=1, PRESC=3: one tick every 4 cycles
      wr32(32'h10, 32'h0000_0301);
      repeat (38) @(posedge clk);
      #1;
      xfer(BASE, 1'b0, 32'h0, 3'b000);
      chk("presc_ack_only", 64'({ack, err}), 64'h2);
      chk("presc_mtime_near_10", 64'(rd >= 32'd9 && rd <= 32'd11), 64'h1);
      rd32(32'h10, 32'h0000_0301, "ctrl_readback");

      // Wrap of the low word and coherent high-word shadow
      wr32(32'h10, 32'h0000_0001);
      wr32(32'h04, 32'h0);
      wr32(32'h00, 32'hFFFF_FFFE);
      repeat (2) @(posedge clk);
      #1;
      rd32(32'h00, 32'h0000_0001, "wrap_lo");
      rd32(32'h04, 32'h0000_0001, "wrap_hi");
      wr32(32'h04, 32'h0000_0005);
      rd32(32'h04, 32'h0000_0001, "shadow_held");
      rd32(32'h00, 32'h0000_0008, "lo_tick_dropped_on_write");
      rd32(32'h04, 32'h0000_0005, "shadow_relatched");

      // irq on compare
      wr32(32'h10, 32'h0);
      wr32(32'h0C, 32'h0);
      wr32(32'h08, 32'd100);
      wr32(32'h04, 32'h0);
      wr32(32'h00, 32'h0);
      wr32(32'h10, 32'h0000_0001);
      repeat (99) @(posedge clk);
      #1;
      chk("irq_low_at_100", 64'(irq), 64'h0);
      @(posedge clk); #1;
      chk("irq_rises", 64'(irq), 64'h1);
      rd32(32'h14, 32'h1, "status_irq");
      wr32(32'h08, 32'd1000);
      chk("irq_held_during_ack", 64'(ack_irq), 64'h1);
      chk("irq_drops", 64'(irq), 64'h0);

      // Error responses leave registers untouched
      wr32(32'h10, 32'h0);
      wr32(32'h00, 32'hA5A5_0000);
      xfer(BASE + 32'h02, 1'b1, 32'h0000_DEAD, 3'b000);
      chk("err_misaligned", 64'({ack, err, rd}), 64'({2'b01, 32'h0}));
      xfer(BASE + 32'h18, 1'b0, 32'h0, 3'b000);
      chk("err_unmapped", 64'({ack, err, rd}), 64'({2'b01, 32'h0}));
      xfer(BASE, 1'b1, 32'h0000_5555, 3'b010);
      chk("err_cti", 64'({ack, err, rd}), 64'({2'b01, 32'h0}));
      xfer(32'h0300_0000, 1'b1, 32'h0000_7777, 3'b000);
      chk("err_base", 64'({ack, err, rd}), 64'({2'b01, 32'h0}));
      rd32(32'h00, 32'hA5A5_0000, "err_no_side_effect");
      xfer(BASE + 32'h08, 1'b0, 32'h0, 3'b111);
      chk("cti_end_of_burst", 64'({ack, err, rd}), 64'({2'b10, 32'd1000}));
      wr32(32'h10, 32'hFFFF_FF00);
      rd32(32'h10, 32'h0000_FF00, "ctrl_reserved_zero");

      // Asynchronous reset mid-response
      wr32(32'h08, 32'h0);
      wr32(32'h10, 32'h0000_0001);
      @(posedge clk); #1;
      ADR = BASE + 32'h14; WE = 1'b0; CTI_O = 3'b000; STB = 1'b1; CYC = 1'b1;
      @(posedge clk); #1;
      chk("pre_reset_ack_irq", 64'({ACK, irq}), 64'h3);
      #2 rst = 1'b0;
      #1;
      chk("async_reset", 64'({ACK, ERR, irq, DAT_O}), 64'h0);
      STB = 1'b0; CYC = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      rd32(32'h00, 32'h0, "mtime_after_reset");
      rd32(32'h0C, 32'hFFFF_FFFF, "mtimecmp_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
